wbuf_axi_drain: RTL and testbench



---
 rtl/wbuf_axi_drain.sv | 138 +++++++++++++
 tb/tb_wbuf_axi_drain.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbuf_axi_drain.sv
// wbuf_axi_drain
//   Drains a store-buffer FIFO onto an AXI4 write port, one single-beat
//   write at a time. The head entry is only retired (fifo_pop) after its
//   write response returns, so the FIFO's RAW match covers in-flight writes.
//   Non-write entries (fifo_wr=0) are retired without any AXI traffic.
//
// Ports
//   clk, resetn                 clock, synchronous active-low reset
//   fifo_empty/wr/addr/data/strb head entry of the store-buffer FIFO
//   fifo_pop                    one-cycle pulse retiring the head entry
//   aw*, w*, b*                 AXI4 write address / data / response channels
//   busy                        FSM not idle
//   err                         sticky, set on any non-OKAY write response
module wbuf_axi_drain #(
    parameter logic [3:0]  AXI_ID     = 4'd1,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  fifo_empty,
    input  logic                  fifo_wr,
    input  logic [ADDR_WIDTH-1:0] fifo_addr,
    input  logic [31:0]           fifo_data,
    input  logic [3:0]            fifo_strb,
    output logic                  fifo_pop,

    output logic [3:0]            awid,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic                  awvalid,
    input  logic                  awready,

    output logic [31:0]           wdata,
    output logic [3:0]            wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,

    input  logic [3:0]            bid,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,

    output logic                  busy,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RESP = 2'd2,
        POP  = 2'd3
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           data_q;
    logic [3:0]            strb_q;

    // A channel is finished once its valid is low, or it handshakes this cycle.
    logic aw_fin;
    logic w_fin;
    assign aw_fin = !awvalid || awready;
    assign w_fin  = !wvalid  || wready;

    // Response ID is not checked: only one transaction is ever outstanding.
    logic unused_bid;
    assign unused_bid = ^bid;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            awvalid  <= 1'b0;
            wvalid   <= 1'b0;
            bready   <= 1'b0;
            fifo_pop <= 1'b0;
            err      <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            strb_q   <= '0;
        end else begin
            fifo_pop <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (fifo_wr) begin
                            addr_q  <= fifo_addr;
                            data_q  <= fifo_data;
                            strb_q  <= fifo_strb;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= SEND;
                        end else begin
                            fifo_pop <= 1'b1;
                            state    <= POP;
                        end
                    end
                end
                SEND: begin
                    if (awvalid && awready) awvalid <= 1'b0;
                    if (wvalid && wready)   wvalid  <= 1'b0;
                    if (aw_fin && w_fin) begin
                        bready <= 1'b1;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    if (bvalid && bready) begin
                        bready   <= 1'b0;
                        fifo_pop <= 1'b1;
                        state    <= POP;
                        if (bresp != 2'b00) err <= 1'b1;
                    end
                end
                POP: begin
                    // fifo_pop was high this cycle, so the FIFO head has
                    // advanced by the time IDLE samples it again.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign awid    = AXI_ID;
    assign awaddr  = addr_q;
    assign awlen   = 8'd0;
    assign awsize  = 3'b010;
    assign awburst = 2'b01;
    assign wdata   = data_q;
    assign wstrb   = strb_q;
    assign wlast   = 1'b1;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_wbuf_axi_drain.sv
// tb_wbuf_axi_drain
//   Directed bench for wbuf_axi_drain. A queue models the store-buffer FIFO,
//   a small AXI slave answers with programmable ready/response delays, and a
//   negedge monitor checks every cycle that each write entry produces exactly
//   one AW and one W transfer carrying its own payload, that responses are
//   only accepted after both transfers, that pops retire entries in order and
//   only after the response, and that err tracks the responses seen.
module tb_wbuf_axi_drain;

    localparam logic [3:0] ID = 4'd5;

    logic        clk = 1'b0;
    logic        resetn;
    logic        fifo_empty, fifo_wr, fifo_pop;
    logic [31:0] fifo_addr, fifo_data;
    logic [3:0]  fifo_strb;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic        busy, err;

    always #5 clk = ~clk;

    wbuf_axi_drain #(
        .AXI_ID     (ID),
        .ADDR_WIDTH (32)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .fifo_empty (fifo_empty),
        .fifo_wr    (fifo_wr),
        .fifo_addr  (fifo_addr),
        .fifo_data  (fifo_data),
        .fifo_strb  (fifo_strb),
        .fifo_pop   (fifo_pop),
        .awid       (awid),
        .awaddr     (awaddr),
        .awlen      (awlen),
        .awsize     (awsize),
        .awburst    (awburst),
        .awvalid    (awvalid),
        .awready    (awready),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wlast      (wlast),
        .wvalid     (wvalid),
        .wready     (wready),
        .bid        (bid),
        .bresp      (bresp),
        .bvalid     (bvalid),
        .bready     (bready),
        .busy       (busy),
        .err        (err)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } ent_t;

    ent_t        fq[$];      // store-buffer FIFO contents, head at [0]
    logic [1:0]  resp_q[$];  // bresp to return for successive writes
    logic [31:0] aw_log[$];  // addresses of accepted AW transfers

    int n_checks = 0;
    int n_errors = 0;

    // slave behaviour knobs
    int aw_delay = 0, w_delay = 0, b_delay = 0;
    bit stray_b  = 1'b0;

    // monitor / model state
    int   aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    bit   b_pend = 1'b0, pop_pend = 1'b0;
    bit   aw_done = 1'b0, w_done = 1'b0, b_done = 1'b0;
    bit   model_err = 1'b0;
    int   n_pops = 0, n_aw = 0;
    logic prev_awv = 1'b0, prev_aw_hs = 1'b0, prev_wv = 1'b0, prev_w_hs = 1'b0, prev_pop = 1'b0;
    logic [31:0] prev_awaddr = '0, prev_wdata = '0;
    logic [3:0]  prev_wstrb = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic drive_inputs();
        if (pop_pend) begin
            void'(fq.pop_front());
            pop_pend = 1'b0;
        end
        fifo_empty = (fq.size() == 0);
        if (fq.size() != 0) begin
            fifo_wr   = fq[0].wr;
            fifo_addr = fq[0].addr;
            fifo_data = fq[0].data;
            fifo_strb = fq[0].strb;
        end else begin
            fifo_wr   = 1'b0;
            fifo_addr = '0;
            fifo_data = '0;
            fifo_strb = '0;
        end
        awready = awvalid && (aw_cnt >= aw_delay);
        wready  = wvalid  && (w_cnt  >= w_delay);
        bvalid  = stray_b || (b_pend && (b_cnt >= b_delay));
        bresp   = stray_b ? 2'b10 : ((resp_q.size() != 0) ? resp_q[0] : 2'b00);
        bid     = ID;
    endtask

    // One clock; returns just after the falling edge with outputs settled.
    task automatic step();
        @(posedge clk);
        #1;
        drive_inputs();
        @(negedge clk);
        #1;
    endtask

    task automatic run_until_idle(input int max);
        int n = 0;
        while ((fq.size() != 0 || busy) && n < max) begin
            step();
            n++;
        end
        chk("drain_timeout", 64'({fq.size() != 0, busy}), 64'(2'b00));
    endtask

    // Per-cycle monitor and model.
    always @(negedge clk) begin
        ent_t h;
        bit   have;
        if (!resetn) begin
            aw_done = 1'b0; w_done = 1'b0; b_done = 1'b0;
            b_pend = 1'b0; pop_pend = 1'b0; model_err = 1'b0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            prev_awv = 1'b0; prev_aw_hs = 1'b0; prev_wv = 1'b0; prev_w_hs = 1'b0; prev_pop = 1'b0;
        end else begin
            have = (fq.size() != 0);
            if (have) h = fq[0];
            else      h = '{wr: 1'b0, addr: '0, data: '0, strb: '0};

            chk("fixed_fields", 64'({awid, awlen, awsize, awburst, wlast}),
                64'({ID, 8'd0, 3'b010, 2'b01, 1'b1}));
            chk("err", 64'(err), 64'(model_err));

            if (prev_aw_hs)    chk("awvalid_drop", 64'(awvalid), 64'(0));
            else if (prev_awv) chk("awvalid_hold", 64'({awvalid, awaddr}), 64'({1'b1, prev_awaddr}));
            if (prev_w_hs)     chk("wvalid_drop", 64'(wvalid), 64'(0));
            else if (prev_wv)  chk("wvalid_hold", 64'({wvalid, wstrb, wdata}), 64'({1'b1, prev_wstrb, prev_wdata}));

            if (awvalid) chk("aw_payload", 64'({have, h.wr, awaddr}), 64'({2'b11, h.addr}));
            if (wvalid)  chk("w_payload", 64'({have, h.wr, wstrb, wdata}), 64'({2'b11, h.strb, h.data}));
            if (bready)  chk("bready_after_send", 64'({have, h.wr, aw_done, w_done, awvalid, wvalid}), 64'(6'b111100));
            if (fifo_pop) chk("pop_legal", 64'({have, prev_pop, (h.wr ? b_done : 1'b1)}), 64'(3'b101));
            if (awvalid || wvalid || bready || fifo_pop) chk("busy_active", 64'(busy), 64'(1));

            if (awvalid && awready) begin
                chk("single_aw", 64'(aw_done), 64'(0));
                aw_done = 1'b1;
                aw_log.push_back(awaddr);
                n_aw++;
            end
            if (wvalid && wready) begin
                chk("single_w", 64'(w_done), 64'(0));
                w_done = 1'b1;
            end
            aw_cnt = (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  = (wvalid  && !wready)  ? w_cnt  + 1 : 0;

            if (bvalid && bready) begin
                if (bresp != 2'b00) model_err = 1'b1;
                b_done = 1'b1;
                b_pend = 1'b0;
                if (resp_q.size() != 0) void'(resp_q.pop_front());
            end else if (b_pend) begin
                b_cnt++;
            end
            if (aw_done && w_done && !b_done && !b_pend) begin
                b_pend = 1'b1;
                b_cnt  = 0;
            end

            if (fifo_pop) begin
                pop_pend = 1'b1;
                n_pops++;
                aw_done = 1'b0; w_done = 1'b0; b_done = 1'b0;
            end

            prev_awv    = awvalid;
            prev_aw_hs  = awvalid && awready;
            prev_wv     = wvalid;
            prev_w_hs   = wvalid && wready;
            prev_pop    = fifo_pop;
            prev_awaddr = awaddr;
            prev_wdata  = wdata;
            prev_wstrb  = wstrb;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, a0, l0;
        logic [31:0] addrs [3];
        resetn = 1'b0;
        drive_inputs();
        repeat (3) step();
        chk("reset_ctrl", 64'({awvalid, wvalid, bready, fifo_pop, busy, err}), 64'(0));
        chk("reset_payload", 64'({wstrb, awaddr}), 64'(0));
        chk("reset_wdata", 64'(wdata), 64'(0));
        resetn = 1'b1;
        step();
        chk("idle_empty", 64'({awvalid, wvalid, fifo_pop, busy}), 64'(0));

        // single write, all readies high
        fq.push_back('{wr: 1'b1, addr: 32'h1C00_0010, data: 32'hDEAD_BEEF, strb: 4'hF});
        step(); // c0
        chk("t1_c0", 64'({busy, awvalid}), 64'(0));
        step(); // c1
        chk("t1_c1_aw", 64'({awvalid, bready, awaddr}), 64'({2'b10, 32'h1C00_0010}));
        chk("t1_c1_w", 64'({wvalid, wstrb, wdata}), 64'({1'b1, 4'hF, 32'hDEAD_BEEF}));
        step(); // c2
        chk("t1_c2", 64'({bready, awvalid, wvalid, fifo_pop}), 64'(4'b1000));
        step(); // c3
        chk("t1_c3", 64'({fifo_pop, bready, busy}), 64'(3'b101));
        step(); // c4
        chk("t1_c4", 64'({fifo_pop, busy}), 64'(0));

        // skewed handshake: awready 3 cycles late, wready immediate
        aw_delay = 3;
        fq.push_back('{wr: 1'b1, addr: 32'h0000_1040, data: 32'h1234_5678, strb: 4'h3});
        step(); // c0
        step(); // c1
        chk("t2_c1", 64'({awvalid, wvalid}), 64'(2'b11));
        step(); // c2
        chk("t2_c2", 64'({awvalid, wvalid, bready}), 64'(3'b100));
        step(); // c3
        step(); // c4
        chk("t2_c4", 64'({awvalid, bready, awaddr}), 64'({2'b10, 32'h0000_1040}));
        step(); // c5
        chk("t2_c5", 64'({awvalid, bready}), 64'(2'b01));
        run_until_idle(20);
        aw_delay = 0;

        // stray response while idle is ignored
        stray_b = 1'b1;
        p0 = n_pops;
        repeat (3) step();
        chk("stray_b", 64'({err, fifo_pop, busy, bready}), 64'(0));
        stray_b = 1'b0;
        step();
        chk("stray_pops", 64'(n_pops - p0), 64'(0));

        // non-write entry
        p0 = n_pops; a0 = n_aw;
        fq.push_back('{wr: 1'b0, addr: 32'hFFFF_FFF0, data: 32'h0, strb: 4'h0});
        step(); // c0
        step(); // c1
        chk("t4_c1", 64'({fifo_pop, awvalid, wvalid, busy}), 64'(4'b1001));
        step(); // c2
        chk("t4_c2", 64'({fifo_pop, busy}), 64'(0));
        chk("t4_counts", 64'({n_pops - p0, n_aw - a0}), 64'({32'd1, 32'd0}));

        // back-to-back drain of three entries
        addrs[0] = 32'h0000_0100; addrs[1] = 32'h0000_0204; addrs[2] = 32'h0000_0308;
        p0 = n_pops; a0 = n_aw; l0 = aw_log.size();
        for (int i = 0; i < 3; i++)
            fq.push_back('{wr: 1'b1, addr: addrs[i], data: 32'hA5A5_0000 + i, strb: 4'hF - 4'(i)});
        run_until_idle(60);
        chk("t5_pops", 64'(n_pops - p0), 64'(3));
        chk("t5_aws", 64'(n_aw - a0), 64'(3));
        for (int i = 0; i < 3; i++)
            chk("t5_order", 64'(aw_log[l0 + i]), 64'(addrs[i]));
        step();
        chk("t5_idle", 64'({awvalid, wvalid, bready, fifo_pop, busy}), 64'(0));

        // error response, then an OKAY write: err stays set
        resp_q.push_back(2'b10);
        p0 = n_pops;
        fq.push_back('{wr: 1'b1, addr: 32'h0000_0800, data: 32'h0BAD_0BAD, strb: 4'h1});
        run_until_idle(20);
        chk("t3_err", 64'({err, n_pops - p0}), 64'({1'b1, 32'd1}));
        resp_q.push_back(2'b00);
        p0 = n_pops;
        fq.push_back('{wr: 1'b1, addr: 32'h0000_0804, data: 32'h600D_600D, strb: 4'hF});
        run_until_idle(20);
        chk("t3_err_sticky", 64'({err, n_pops - p0}), 64'({1'b1, 32'd1}));

        // reset in RESP before the response: abort, then re-issue the same entry
        b_delay = 50;
        p0 = n_pops;
        fq.push_back('{wr: 1'b1, addr: 32'h2000_0ABC, data: 32'hCAFE_F00D, strb: 4'h6});
        step(); // c0
        step(); // c1
        step(); // c2
        chk("t6_resp", 64'({bready, bvalid}), 64'(2'b10));
        resetn = 1'b0;
        step();
        chk("t6_reset", 64'({bready, fifo_pop, busy, err, awvalid, wvalid}), 64'(0));
        chk("t6_no_pop", 64'(n_pops - p0), 64'(0));
        b_delay = 0;
        resetn = 1'b1;
        step();
        chk("t6_reissue_aw", 64'({awvalid, awaddr}), 64'({1'b1, 32'h2000_0ABC}));
        chk("t6_reissue_w", 64'({wvalid, wstrb, wdata}), 64'({1'b1, 4'h6, 32'hCAFE_F00D}));
        run_until_idle(20);
        chk("t6_pops", 64'({err, n_pops - p0}), 64'({1'b0, 32'd1}));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
